// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 constants (register numbers, field positions, exception codes).
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

  typedef logic [4:0] exc_code_t;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LSB = 10;

  // Cause field positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  // EXC_NONE is an otherwise unused code so that 0 can mean "interrupt"
  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_NONE = 5'h1F;

endpackage

// File: rtl/cp0_timer_if.sv
// cp0_timer_if: mtc0/mfc0 register access bus between pipeline and CP0.
// Latency: write lands on the next clk edge; read data is combinational.
// Backpressure: none, every access completes in one cycle.
interface cp0_timer_if;
  logic        we;     // mtc0 write enable
  logic [4:0]  addr;   // register number
  logic [31:0] wdata;  // mtc0 write data
  logic [31:0] rdata;  // mfc0 read data

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/cp0_count.sv
// cp0_count: free-running Count, Compare and sticky timer-interrupt flag TI.
// Latency: Count/Compare writes and TI updates take effect on the next clk edge.
// Backpressure: none. Ports: count/compare write strobes + data in; Count, Compare, TI out.
module cp0_count (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    // a software load replaces this cycle's increment
    count_d   = count_we_i ? wdata_i : count_q + 32'd1;
    compare_d = compare_we_i ? wdata_i : compare_q;
    // match is against the value Count is about to take; a Compare write wins
    if (compare_we_i) ti_d = 1'b0;
    else              ti_d = ti_q | (count_d == compare_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 SR/Cause/EPC/PRId with exception capture and optional Count/Compare timer.
// Latency: req/epc_out/rdata combinational; captures and mtc0 writes land on the next clk edge.
// Backpressure: none. Ports: clk, reset_n, mtc0/mfc0 bus, victim pc/bd/exc_code, hw_int, exl_clr;
//   outputs epc_out, sr_out, req, timer_irq.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int          NUM_INT   = 6,
  parameter int          HAS_TIMER = 1,
  parameter logic [31:0] PRID      = 32'h0000_0007
) (
  input  logic               clk,
  input  logic               reset_n,
  cp0_timer_if.slave         bus,
  input  logic [31:0]        vpc,
  input  logic               is_bd,
  input  logic [4:0]         exc_code,
  input  logic [NUM_INT-1:0] hw_int,
  input  logic               exl_clr,
  output logic [31:0]        epc_out,
  output logic [31:0]        sr_out,
  output logic               req,
  output logic               timer_irq
);

  logic [NUM_INT-1:0] im_q, im_d, ip_q, ip_d, pending;
  logic               exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  exc_code_t          exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        count_val, compare_val, victim_pc;
  logic [31:0]        sr_rd, cause_rd, rdata_mux;
  logic               ti, int_qual, exc_vld, wr_sr, wr_cause, wr_epc;

  if (HAS_TIMER != 0) begin : g_timer
    logic count_we, compare_we;
    // any capture this cycle drops the timer writes as well
    assign count_we   = bus.we & ~req & (bus.addr == ADDR_COUNT);
    assign compare_we = bus.we & ~req & (bus.addr == ADDR_COMPARE);
    cp0_count u_count (
      .clk          (clk),
      .reset_n      (reset_n),
      .count_we_i   (count_we),
      .compare_we_i (compare_we),
      .wdata_i      (bus.wdata),
      .count_o      (count_val),
      .compare_o    (compare_val),
      .ti_o         (ti)
    );
  end else begin : g_no_timer
    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
  end

  always_comb begin
    // TI shares the top interrupt line with the highest external input
    pending              = hw_int;
    pending[NUM_INT-1]   = hw_int[NUM_INT-1] | ti;
    int_qual             = (|(im_q & pending)) & ie_q;
    exc_vld              = (exc_code != EXC_NONE);
    req                  = (int_qual | exc_vld) & ~exl_q;
    victim_pc            = is_bd ? vpc - 32'd4 : vpc;
    epc_out              = req ? victim_pc : epc_q;
    wr_sr                = bus.we & ~req & (bus.addr == ADDR_SR);
    wr_cause             = bus.we & ~req & (bus.addr == ADDR_CAUSE);
    wr_epc               = bus.we & ~req & (bus.addr == ADDR_EPC);
  end

  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = pending;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = is_bd;
      epc_d = victim_pc;
      exc_d = int_qual ? EXC_INT : exc_code;
    end else begin
      if (exl_clr) exl_d = 1'b0;
      // an SR write in the eret cycle takes EXL from wdata
      if (wr_sr) begin
        im_d  = bus.wdata[SR_IM_LSB +: NUM_INT];
        exl_d = bus.wdata[SR_EXL];
        ie_d  = bus.wdata[SR_IE];
      end
      if (wr_cause) begin
        bd_d  = bus.wdata[CAUSE_BD];
        exc_d = bus.wdata[CAUSE_EXC_LSB +: 5];
      end
      if (wr_epc) epc_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
      ip_q  <= '0;
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
      ip_q  <= ip_d;
    end
  end

  always_comb begin
    sr_rd                              = '0;
    sr_rd[SR_IM_LSB +: NUM_INT]        = im_q;
    sr_rd[SR_EXL]                      = exl_q;
    sr_rd[SR_IE]                       = ie_q;
    cause_rd                           = '0;
    cause_rd[CAUSE_BD]                 = bd_q;
    cause_rd[CAUSE_TI]                 = ti;
    cause_rd[CAUSE_IP_LSB +: NUM_INT]  = ip_q;
    cause_rd[CAUSE_EXC_LSB +: 5]       = exc_q;
    case (bus.addr)
      ADDR_COUNT:   rdata_mux = count_val;
      ADDR_COMPARE: rdata_mux = compare_val;
      ADDR_SR:      rdata_mux = sr_rd;
      ADDR_CAUSE:   rdata_mux = cause_rd;
      ADDR_EPC:     rdata_mux = epc_q;
      ADDR_PRID:    rdata_mux = PRID;
      default:      rdata_mux = '0;
    endcase
  end

  assign bus.rdata = rdata_mux;
  assign sr_out    = sr_rd;
  assign timer_irq = ti;

endmodule

// File: doc/cp0_timer.md
CP0_TIMER -- requirements
Module: cp0_timer

Interface
REQ-001 SHALL have parameter NUM_INT, default 6, number of external interrupt lines (1..8).
REQ-002 SHALL have parameter HAS_TIMER, default 1, which instantiates Count/Compare when 1.
REQ-003 SHALL have parameter PRID, default 32'h0000_0007, the read-only PRId value.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports we (in, 1, mtc0 write enable), addr (in, 5, register number), wdata (in, 32, write data) and rdata (out, 32, mfc0 read data).
REQ-007 SHALL have ports vpc (in, 32, victim PC), is_bd (in, 1, victim in delay slot), exc_code (in, 5, exception code; EXC_NONE means no exception) and hw_int (in, NUM_INT, external interrupt lines).
REQ-008 SHALL have ports exl_clr (in, 1, eret), epc_out (out, 32, effective EPC), sr_out (out, 32, SR) and req (out, 1, take handler).
REQ-009 SHALL have port timer_irq (out, 1, registered copy of Cause.TI).

Function
REQ-010 SR SHALL implement IM=[10+NUM_INT-1:10], EXL=[1] and IE=[0]; other bits SHALL read 0 and ignore writes.
REQ-011 Cause SHALL implement BD=[31], TI=[30], IP=[10+NUM_INT-1:10] and ExcCode=[6:2]; other bits SHALL read 0.
REQ-012 rdata SHALL be combinational: addr 9 gives Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRID; all other addresses give 0, and 9/11 give 0 when HAS_TIMER=0.
REQ-013 Every cycle IP SHALL load hw_int, with IP[NUM_INT-1] loading hw_int[NUM_INT-1] OR TI.
REQ-014 The effective pending vector SHALL be IP as defined in REQ-013 but computed from the current-cycle hw_int and TI.
REQ-015 req SHALL be combinational: ((|(IM & pending)) & IE | exc_code!=EXC_NONE) & !EXL.
REQ-016 epc_out SHALL be req ? (is_bd ? vpc-4 : vpc) : EPC, with 32-bit wrap.
REQ-017 When req is high, the edge SHALL set EXL=1, BD=is_bd and EPC=epc_out, and set ExcCode=EXC_INT if an interrupt qualifies (interrupt has priority), else exc_code.
REQ-018 Priority SHALL be req > exl_clr > we; when req is high, exl_clr and all software writes (including Count/Compare) SHALL be dropped.
REQ-019 exl_clr without req SHALL clear EXL; a same-cycle we to SR SHALL then apply with EXL taken from wdata.
REQ-020 A write to Cause SHALL update only IM-independent writable fields (none except software-defined ExcCode/BD); IP and TI SHALL NOT be writable.
REQ-021 Count SHALL increment by 1 every cycle and wrap 32'hFFFF_FFFF to 0.
REQ-022 A write to Count SHALL load wdata and suppress that cycle's increment.
REQ-023 TI SHALL be set (sticky) on the edge where the next Count equals Compare.
REQ-024 A write to Compare SHALL load wdata and clear TI; if set and clear coincide, the clear SHALL win.
REQ-025 timer_irq SHALL equal TI; with HAS_TIMER=0, TI SHALL be constant 0.

Reset
REQ-026 reset_n low SHALL immediately force SR, Cause, EPC, Count and Compare to 0; req then depends only on exc_code, and rdata reflects zeros.
REQ-027 Reset mid-operation SHALL abort any pending capture; the first post-reset edge SHALL increment Count to 1.

Structure
REQ-028 Register addresses, field positions, EXC_NONE and EXC_INT SHALL live in the shared cp0_pkg constants package.
REQ-029 Count/Compare/TI SHALL be one sub-module, cp0_count, generated only when HAS_TIMER=1.

Verification
REQ-030 Apply SR=32'h0000_0401 and hw_int[0]=1 -> req=1 same cycle; after the edge ExcCode=0 (EXC_INT), EXL=1, and req drops.
REQ-031 Apply vpc=32'h0000_3008 with is_bd=1 and exc_code=4 -> epc_out=32'h0000_3004; after the edge EPC=32'h0000_3004 and BD=1.
REQ-032 Apply we with addr 12 in the same cycle as exc_code=10 -> the SR write is dropped; EXL=1 and ExcCode=10.
REQ-033 Write Compare=5 and Count=0 -> TI and timer_irq rise on the 5th edge; writing Compare=100 clears TI next cycle.
REQ-034 Write Count=32'hFFFF_FFFF -> one edge later Count=0 with no TI when Compare=5.
REQ-035 Pulse reset_n low with no clock edge while EXL=1 -> all registers read 0 immediately.
